// File: rtl/bj_pkg.sv
// Shared blackjack dealing definitions: deck size, suit/requester encodings, FSM states.
package bj_pkg;
  localparam int DECK_SIZE = 52;
  localparam int IDX_W     = 6;
  localparam int PLAYER    = 0;
  localparam int DEALER    = 1;

  typedef enum logic [1:0] {
    SUIT_DIAMOND = 2'd0,
    SUIT_CLUB    = 2'd1,
    SUIT_HEART   = 2'd2,
    SUIT_SPADE   = 2'd3
  } suit_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAW    = 2'd1,
    S_SCAN    = 2'd2,
    S_DELIVER = 2'd3
  } state_e;

  // (value-1)*4 + suit; only meaningful for value 1..13
  function automatic logic [IDX_W-1:0] card_idx(input logic [3:0] v, input logic [1:0] s);
    logic [3:0] vm1;
    vm1 = v - 4'd1;
    return {vm1, s};
  endfunction
endpackage

// File: rtl/deal_arbiter_if.sv
// Request/draw/card bus between the requesters and the dealing arbiter.
interface deal_arbiter_if;
  logic [1:0] req;
  logic       shuffle;
  logic [3:0] rng_value;
  logic [1:0] rng_suit;
  logic [1:0] ack;
  logic       card_valid;
  logic [3:0] card_value;
  logic [1:0] card_suit;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       busy;

  modport master (
    output req, shuffle, rng_value, rng_suit,
    input  ack, card_valid, card_value, card_suit, cards_left, deck_empty, busy
  );
  modport slave (
    input  req, shuffle, rng_value, rng_suit,
    output ack, card_valid, card_value, card_suit, cards_left, deck_empty, busy
  );
endinterface

// File: rtl/deck_mask.sv
// Used-card mask and remaining-card counter; empty flag lags the counter by one cycle.
module deck_mask
  import bj_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_set,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic [IDX_W-1:0] i_test_idx,
  output logic             o_test_used,
  output logic [5:0]       o_cards_left,
  output logic             o_empty
);
  logic [DECK_SIZE-1:0] r_mask;
  logic [5:0]           r_left;
  logic                 r_empty;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_mask  <= '0;
      r_left  <= 6'(DECK_SIZE);
      r_empty <= 1'b0;
    end else begin
      if (i_set) begin
        r_mask[i_set_idx] <= 1'b1;
        r_left            <= r_left - 6'd1;
      end
      r_empty <= (r_left == 6'd0);
    end
  end

  // indices past the deck read as used so they can never be taken
  assign o_test_used  = (i_test_idx >= 6'(DECK_SIZE)) ? 1'b1 : r_mask[i_test_idx];
  assign o_cards_left = r_left;
  assign o_empty      = r_empty;
endmodule

// File: rtl/deal_arbiter.sv
// Round-robin card dealer: RNG draws with rejection, linear-scan fallback after MAX_RETRY misses.
module deal_arbiter
  import bj_pkg::*;
#(
  parameter int MAX_RETRY = 8
) (
  input  logic clk,
  input  logic rst,
  deal_arbiter_if.slave bus
);
  localparam int RW = $clog2(MAX_RETRY) + 1;

  state_e           r_state, w_next;
  logic             r_dest;
  logic             r_rr_dealer;
  logic [RW-1:0]    r_retry;
  logic [IDX_W-1:0] r_scan_idx;
  logic [3:0]       r_value;
  logic [1:0]       r_suit;

  logic [IDX_W-1:0] w_draw_idx, w_test_idx;
  logic             w_rng_ok, w_used, w_take, w_clear, w_grant, w_winner, w_last_try;
  logic [5:0]       w_left;
  logic             w_empty;

  assign w_draw_idx = card_idx(bus.rng_value, bus.rng_suit);
  assign w_rng_ok   = (bus.rng_value >= 4'd1) && (bus.rng_value <= 4'd13);
  assign w_test_idx = (r_state == S_SCAN) ? r_scan_idx : w_draw_idx;
  assign w_take     = (((r_state == S_DRAW) && w_rng_ok) || (r_state == S_SCAN)) && !w_used;
  assign w_clear    = (r_state == S_IDLE) && bus.shuffle;
  assign w_grant    = (r_state == S_IDLE) && !bus.shuffle && (w_left != 6'd0) && (|bus.req);
  assign w_winner   = (bus.req == 2'b11) ? r_rr_dealer : bus.req[1];
  assign w_last_try = (r_retry == RW'(MAX_RETRY - 1));

  deck_mask u_mask (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_set        (w_take),
    .i_set_idx    (w_test_idx),
    .i_test_idx   (w_test_idx),
    .o_test_used  (w_used),
    .o_cards_left (w_left),
    .o_empty      (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant) w_next = S_DRAW;
      S_DRAW:    if (w_take) w_next = S_DELIVER;
                 else if (w_last_try) w_next = S_SCAN;
      S_SCAN:    if (w_take) w_next = S_DELIVER;
      S_DELIVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest      <= 1'b0;
      r_rr_dealer <= 1'b0;
      r_retry     <= '0;
      r_scan_idx  <= '0;
      r_value     <= '0;
      r_suit      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_dest  <= w_winner;
          r_retry <= '0;
        end
        S_DRAW: if (w_take) begin
          r_value <= bus.rng_value;
          r_suit  <= bus.rng_suit;
        end else begin
          r_retry    <= r_retry + RW'(1);
          r_scan_idx <= '0;
        end
        S_SCAN: if (w_take) begin
          r_value <= r_scan_idx[5:2] + 4'd1;
          r_suit  <= r_scan_idx[1:0];
        end else begin
          r_scan_idx <= r_scan_idx + 6'd1;
        end
        // the requester just served loses the next tie
        S_DELIVER: r_rr_dealer <= ~r_dest;
        default: ;
      endcase
    end
  end

  assign bus.card_valid = (r_state == S_DELIVER);
  assign bus.ack        = (r_state == S_DELIVER) ? {r_dest, ~r_dest} : 2'b00;
  assign bus.card_value = r_value;
  assign bus.card_suit  = r_suit;
  assign bus.cards_left = w_left;
  assign bus.deck_empty = w_empty;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_deal_arbiter.sv
// Randomized bench for deal_arbiter against a transaction-level deck model.
`timescale 1ns/1ps
module tb_deal_arbiter;
  localparam int MAXR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  deal_arbiter_if bus();
  deal_arbiter #(.MAX_RETRY(MAXR)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // deck model
  bit used[52];
  int left_m;
  bit rr_dealer_m;

  // expectations for the compare process
  int exp_cyc = -1, busy_lo = -1, busy_hi = -1;
  int exp_ack, exp_val, exp_suit, exp_left;
  bit chk_en = 0;

  // captured deliveries
  int cap_cyc, cap_val, cap_suit, cap_ack, cap_left, cap_empty;
  bit seen[52];
  int n_seen = 0;

  task automatic model_clear();
    for (int i = 0; i < 52; i++) begin used[i] = 0; seen[i] = 0; end
    left_m = 52;
    n_seen = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("card_valid", int'(bus.card_valid), int'(cyc == exp_cyc));
      chk("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (cyc == exp_cyc) begin
        chk("ack", int'(bus.ack), exp_ack);
        chk("card_value", int'(bus.card_value), exp_val);
        chk("card_suit", int'(bus.card_suit), exp_suit);
        chk("cards_left", int'(bus.cards_left), exp_left);
      end else begin
        chk("ack_quiet", int'(bus.ack), 0);
      end
      if (bus.card_valid) begin
        int ix;
        cap_cyc = cyc; cap_val = int'(bus.card_value); cap_suit = int'(bus.card_suit);
        cap_ack = int'(bus.ack); cap_left = int'(bus.cards_left); cap_empty = int'(bus.deck_empty);
        if (cap_val >= 1 && cap_val <= 13) begin
          ix = (cap_val - 1) * 4 + cap_suit;
          chk("distinct", int'(seen[ix]), 0);
          seen[ix] = 1;
          n_seen++;
        end
      end
    end
  end

  // mode 0: random rng, 1: fixed (5,2), 2: only illegal values
  task automatic draw(input logic [1:0] r, input int mode, input bit drop,
                      input bit shuf_mid, input bit hold);
    int k, w, found, idx, del, j;
    int sv[MAXR];
    int ss[MAXR];
    k = cyc;
    w = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : (rr_dealer_m ? 1 : 0);
    found = -1; idx = -1;
    for (int t = 0; t < MAXR; t++) begin
      case (mode)
        1:       begin sv[t] = 5; ss[t] = 2; end
        2:       begin sv[t] = (t % 3 == 0) ? 0 : (t % 3 == 1) ? 14 : 15; ss[t] = $urandom_range(0, 3); end
        default: begin sv[t] = $urandom_range(0, 15); ss[t] = $urandom_range(0, 3); end
      endcase
      if (found < 0 && sv[t] >= 1 && sv[t] <= 13 && !used[(sv[t] - 1) * 4 + ss[t]]) begin
        found = t;
        idx = (sv[t] - 1) * 4 + ss[t];
      end
    end
    if (found >= 0) del = k + 2 + found;
    else begin
      for (int i = 51; i >= 0; i--) if (!used[i]) idx = i;
      del = k + MAXR + idx + 2;
    end
    used[idx] = 1;
    left_m--;
    rr_dealer_m = (w == 0);
    exp_ack = (w == 0) ? 1 : 2;
    exp_val = idx / 4 + 1;
    exp_suit = idx % 4;
    exp_left = left_m;
    busy_lo = k + 1; busy_hi = del; exp_cyc = del;
    bus.req = r;
    while (cyc <= del) begin
      @(posedge clk); #1;
      j = cyc - k - 1;
      if (j >= 0 && j < MAXR) begin
        bus.rng_value = 4'(sv[j]); bus.rng_suit = 2'(ss[j]);
      end else begin
        bus.rng_value = 4'($urandom_range(0, 15)); bus.rng_suit = 2'($urandom_range(0, 3));
      end
      if (drop && cyc == k + 1) bus.req = 2'b00;
      bus.shuffle = shuf_mid && (cyc == k + 1);
    end
    if (!hold) bus.req = 2'b00;
  endtask

  initial begin
    int k0;
    int acks[4];
    logic [1:0] rr;
    bus.req = 0; bus.shuffle = 0; bus.rng_value = 0; bus.rng_suit = 0;
    model_clear();
    rr_dealer_m = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cards_left", int'(bus.cards_left), 52);
    chk("rst_deck_empty", int'(bus.deck_empty), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_valid", int'(bus.card_valid), 0);
    chk("rst_value", int'(bus.card_value), 0);
    chk("rst_suit", int'(bus.card_suit), 0);
    @(posedge clk); #1 rst = 0;
    chk_en = 1;

    // first draw (5,2), minimum latency
    k0 = cyc;
    draw(2'b01, 1, 0, 0, 0);
    chk("lit_lat2", cap_cyc - k0, 2);
    chk("lit_val5", cap_val, 5);
    chk("lit_suit2", cap_suit, 2);
    chk("lit_ack01", cap_ack, 1);
    chk("lit_left51", cap_left, 51);

    // (5,2) already gone: scan takes index 0
    k0 = cyc;
    draw(2'b01, 1, 0, 0, 0);
    chk("lit_scan_lat", cap_cyc - k0, MAXR + 2);
    chk("lit_scan_val", cap_val, 1);
    chk("lit_scan_suit", cap_suit, 0);

    // illegal rng values only: scan takes index 1
    k0 = cyc;
    draw(2'b10, 2, 0, 0, 0);
    chk("lit_bad_lat", cap_cyc - k0, MAXR + 3);
    chk("lit_bad_val", cap_val, 1);
    chk("lit_bad_suit", cap_suit, 1);
    chk("lit_bad_ack", cap_ack, 2);

    // both held: strict alternation
    for (int i = 0; i < 4; i++) begin
      draw(2'b11, 0, 0, 0, 1);
      acks[i] = cap_ack;
    end
    bus.req = 0;
    chk("rr0", acks[0], 1);
    chk("rr1", acks[1], 2);
    chk("rr2", acks[2], 1);
    chk("rr3", acks[3], 2);

    draw(2'b01, 0, 1, 0, 0);   // req dropped after grant
    draw(2'b10, 0, 0, 1, 0);   // shuffle while drawing is ignored

    while (left_m > 0) begin
      rr = 2'($urandom_range(1, 3));
      draw(rr, 0, 0, 0, 0);
    end
    chk("empty_at_deliver", cap_empty, 0);
    @(negedge clk);
    chk("deck_empty_after", int'(bus.deck_empty), 1);
    chk("cards_left_zero", int'(bus.cards_left), 0);
    chk("all_52_seen", n_seen, 52);
    @(posedge clk); #1;
    bus.req = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    bus.shuffle = 1;
    @(posedge clk); #1;
    bus.shuffle = 0; bus.req = 0;
    model_clear();
    @(negedge clk);
    chk("shuffle_left", int'(bus.cards_left), 52);
    chk("shuffle_empty", int'(bus.deck_empty), 0);

    // shuffle beats a simultaneous request
    @(posedge clk); #1;
    bus.shuffle = 1; bus.req = 2'b01;
    @(posedge clk); #1;
    bus.shuffle = 0; bus.req = 0;
    @(negedge clk);
    chk("shuffle_no_grant", int'(bus.busy), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) draw(2'($urandom_range(1, 3)), 0, 0, 0, 0);

    // reset mid-draw discards the card
    k0 = cyc;
    exp_cyc = -1; busy_lo = k0 + 1; busy_hi = k0 + 1;
    bus.req = 2'b01;
    @(posedge clk); #1;
    rst = 1; bus.req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_valid", int'(bus.card_valid), 0);
    chk("rstmid_left", int'(bus.cards_left), 52);
    chk("rstmid_busy", int'(bus.busy), 0);
    @(posedge clk); #1 rst = 0;
    model_clear();
    rr_dealer_m = 0;

    draw(2'b11, 0, 0, 0, 0);
    chk("rr_after_rst", cap_ack, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
